// File: rtl/pmu_intr_ctrl.sv
// ---------------------------------------------------------------------------
// pmu_intr_ctrl
//   Interrupt controller that sits beside the PMU. It collects the PMU
//   overflow/quota interrupts, the per-core MCCU interrupts and the RDC
//   interrupt. It latches rising edges into a PENDING register and combines
//   the pending bits with a MASK into one registered host interrupt.
//   A small register file (MASK, PENDING, RAW, CAUSE, COUNT) is exposed
//   through a simple strobe-based read/write port with registered read data.
//
// Ports
//   clk_i            single clock, rising edge
//   rstn_i           synchronous active-low reset
//   intr_overflow_i  source 0
//   intr_quota_i     source 1
//   intr_MCCU_i      sources 2 .. N_CORES+1
//   intr_RDC_i       source N_CORES+2
//   wr_en_i          write strobe (one write per cycle)
//   rd_en_i          read strobe
//   addr_i           register index: 0 MASK, 1 PENDING, 2 RAW, 3 CAUSE,
//                    4 COUNT, 5-7 reserved
//   wdata_i          write data
//   rdata_o          registered read data, held between reads
//   rvalid_o         high the cycle after a read strobe
//   irq_o            registered combined interrupt
// ---------------------------------------------------------------------------
module pmu_intr_ctrl #(
  parameter int REG_WIDTH = 32,
  parameter int N_CORES   = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 intr_overflow_i,
  input  logic                 intr_quota_i,
  input  logic [N_CORES-1:0]   intr_MCCU_i,
  input  logic                 intr_RDC_i,
  input  logic                 wr_en_i,
  input  logic                 rd_en_i,
  input  logic [2:0]           addr_i,
  input  logic [REG_WIDTH-1:0] wdata_i,
  output logic [REG_WIDTH-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 irq_o
);

  localparam int N_SRC = N_CORES + 3;

  localparam logic [2:0] ADDR_MASK    = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_RAW     = 3'd2;
  localparam logic [2:0] ADDR_CAUSE   = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  logic [N_SRC-1:0]     src_s;
  logic [N_SRC-1:0]     prev_r;
  logic [N_SRC-1:0]     pending_r;
  logic [N_SRC-1:0]     mask_r;
  logic [N_SRC-1:0]     rise_s;
  logic [N_SRC-1:0]     w1c_s;
  logic [N_SRC-1:0]     pending_next_s;
  logic [N_SRC-1:0]     enabled_s;
  logic                 wr_mask_s;
  logic                 wr_pending_s;
  logic                 wr_count_s;
  logic                 irq_next_s;
  logic                 irq_r;
  logic                 rvalid_r;
  logic [REG_WIDTH-1:0] count_r;
  logic [REG_WIDTH-1:0] cause_s;
  logic [REG_WIDTH-1:0] rd_mux_s;
  logic [REG_WIDTH-1:0] rdata_r;
  logic                 unused_wdata_s;

  // Index of the lowest set bit; 0 when the vector is empty (the caller
  // qualifies the result with the "any" flag).
  function automatic logic [7:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 8'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Source vector in fixed index order: overflow, quota, MCCU[*], RDC.
  assign src_s = {intr_RDC_i, intr_MCCU_i, intr_quota_i, intr_overflow_i};

  // Only the low N_SRC bits of write data are architecturally used.
  assign unused_wdata_s = ^wdata_i;

  // Write decode, edge detection and next-state for the pending bits.
  always_comb begin
    wr_mask_s    = wr_en_i && (addr_i == ADDR_MASK);
    wr_pending_s = wr_en_i && (addr_i == ADDR_PENDING);
    wr_count_s   = wr_en_i && (addr_i == ADDR_COUNT);
    rise_s       = src_s & ~prev_r;
    if (wr_pending_s) begin
      w1c_s = wdata_i[N_SRC-1:0];
    end else begin
      w1c_s = {N_SRC{1'b0}};
    end
    // Set is OR'ed in after the clear so a same-cycle edge wins over W1C.
    pending_next_s = (pending_r & ~w1c_s) | rise_s;
    enabled_s      = pending_r & mask_r;
    irq_next_s     = |enabled_s;
  end

  // CAUSE: lowest enabled pending index plus a valid flag in the MSB.
  always_comb begin
    cause_s                = {REG_WIDTH{1'b0}};
    cause_s[7:0]           = lowest_idx(enabled_s);
    cause_s[REG_WIDTH-1]   = |enabled_s;
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_mux_s = {REG_WIDTH{1'b0}};
    case (addr_i)
      ADDR_MASK:    rd_mux_s[N_SRC-1:0] = mask_r;
      ADDR_PENDING: rd_mux_s[N_SRC-1:0] = pending_r;
      ADDR_RAW:     rd_mux_s[N_SRC-1:0] = src_s;
      ADDR_CAUSE:   rd_mux_s            = cause_s;
      ADDR_COUNT:   rd_mux_s            = count_r;
      default:      rd_mux_s            = {REG_WIDTH{1'b0}};
    endcase
  end

  // Interrupt capture state: previous sources, pending, mask and irq.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prev_r    <= {N_SRC{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      prev_r    <= src_s;
      pending_r <= pending_next_s;
      if (wr_mask_s) begin
        mask_r <= wdata_i[N_SRC-1:0];
      end
      irq_r     <= irq_next_s;
    end
  end

  // Saturating count of irq rising transitions; any COUNT write clears it.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_r <= {REG_WIDTH{1'b0}};
    end else if (wr_count_s) begin
      count_r <= {REG_WIDTH{1'b0}};
    end else if (irq_next_s && !irq_r && !(&count_r)) begin
      count_r <= count_r + {{(REG_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rdata_r  <= {REG_WIDTH{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_en_i;
      if (rd_en_i) begin
        rdata_r <= rd_mux_s;
      end
    end
  end

  assign rdata_o  = rdata_r;
  assign rvalid_o = rvalid_r;
  assign irq_o    = irq_r;

endmodule

// File: tb/tb_pmu_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pmu_intr_ctrl
//   Self-checking bench for pmu_intr_ctrl (default parameters). Read
//   expectations are queued when a read is issued and compared when rvalid_o
//   is seen; interrupt behaviour is checked inline in each scenario task.
// ---------------------------------------------------------------------------
module tb_pmu_intr_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        intr_overflow;
  logic        intr_quota;
  logic [3:0]  intr_mccu;
  logic        intr_rdc;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  addr_q[$];

  pmu_intr_ctrl #(.REG_WIDTH(32), .N_CORES(4)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .intr_overflow_i (intr_overflow),
    .intr_quota_i    (intr_quota),
    .intr_MCCU_i     (intr_mccu),
    .intr_RDC_i      (intr_rdc),
    .wr_en_i         (wr_en),
    .rd_en_i         (rd_en),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .rdata_o         (rdata),
    .rvalid_o        (rvalid),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare read data when the DUT presents it.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rdata=%08h with no read pending", rdata);
      end else begin
        logic [31:0] e;
        logic [2:0]  a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL read_addr%0d got %08h expected %08h", a, rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    intr_overflow = 1'b0; intr_quota = 1'b0; intr_mccu = 4'h0; intr_rdc = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wdata = 32'h0;
    tick(); tick();
    checks++;
    if (irq !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got irq=%b rvalid=%b rdata=%08h expected 0/0/0", irq, rvalid, rdata);
    end
    rstn = 1'b1;
    tick();
    rd(3'd0, 32'h0);
    rd(3'd1, 32'h0);
    rd(3'd4, 32'h0);
  endtask

  task automatic test_quota_pulse();
    wr(3'd0, 32'h7F);
    intr_quota = 1'b1;
    tick();
    intr_quota = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL quota_irq_early got %b expected 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL quota_irq_rise got %b expected 1", irq);
    end
    rd(3'd3, 32'h8000_0001);
    rd(3'd1, 32'h0000_0002);
    rd(3'd4, 32'h0000_0001);
    wr(3'd1, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_irq_same_edge got %b expected 1", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_drop got %b expected 0", irq);
    end
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0);
  endtask

  task automatic test_mccu_hold();
    intr_mccu = 4'b0100;
    tick(); tick(); tick();
    wr(3'd1, 32'h10);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mccu_irq_after_clear got %b expected 0", irq);
    end
    for (int i = 0; i < 4; i++) tick();
    rd(3'd1, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mccu_no_reset_while_held got irq=%b expected 0", irq);
    end
    intr_mccu = 4'b0000;
    rd(3'd4, 32'h1);
    wr(3'd4, 32'h0);
  endtask

  task automatic test_mask_later();
    wr(3'd0, 32'h0);
    intr_rdc = 1'b1;
    tick();
    intr_rdc = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_irq got %b expected 0", irq);
    end
    rd(3'd1, 32'h40);
    wr(3'd0, 32'h40);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL unmask_irq_early got %b expected 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq got %b expected 1", irq);
    end
    rd(3'd4, 32'h1);
    wr(3'd1, 32'h40);
    tick(); tick();
    wr(3'd4, 32'h0);
  endtask

  task automatic test_set_wins();
    wr(3'd0, 32'h7F);
    intr_overflow = 1'b1;
    wr(3'd1, 32'h1);
    intr_overflow = 1'b0;
    rd(3'd1, 32'h1);
    wr(3'd1, 32'h1);
    rd(3'd1, 32'h0);
    tick();
  endtask

  task automatic test_cause();
    intr_overflow = 1'b1;
    intr_quota    = 1'b1;
    tick();
    intr_overflow = 1'b0;
    intr_quota    = 1'b0;
    rd(3'd3, 32'h8000_0000);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL cause_rvalid got %b expected 1", rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cause_rvalid_one_cycle got %b expected 0", rvalid);
    end
    wr(3'd1, 32'h1);
    rd(3'd3, 32'h8000_0001);
    wr(3'd1, 32'h2);
    rd(3'd3, 32'h0);
    // RAW is read-only and tracks the live sources.
    intr_mccu = 4'b1010;
    intr_rdc  = 1'b1;
    rd(3'd2, 32'h68);
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'h68);
    intr_mccu = 4'b0000;
    intr_rdc  = 1'b0;
    wr(3'd1, 32'h7F);
    tick(); tick();
    wr(3'd4, 32'h0);
  endtask

  task automatic test_regs();
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h7F);
    rd(3'd5, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0);
    rd(3'd0, 32'h7F);
    // Simultaneous read and write returns the old value.
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd0; wdata = 32'h15;
    exp_q.push_back(32'h7F);
    addr_q.push_back(3'd0);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    rd(3'd0, 32'h15);
    rd(3'd1, 32'h0);
    rd(3'd7, 32'h0);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rvalid got %b expected 1", rvalid);
    end
    tick();
  endtask

  task automatic test_reset_held();
    intr_overflow = 1'b1; intr_quota = 1'b1; intr_mccu = 4'hF; intr_rdc = 1'b1;
    tick(); tick();
    rstn  = 1'b0;
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd0; wdata = 32'h7F;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    checks++;
    if (irq !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_held_outputs got irq=%b rvalid=%b rdata=%08h expected 0/0/0", irq, rvalid, rdata);
    end
    tick();
    rstn = 1'b1;
    tick();
    rd(3'd1, 32'h7F);
    rd(3'd0, 32'h0);
    rd(3'd4, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_irq got %b expected 0", irq);
    end
    intr_overflow = 1'b0; intr_quota = 1'b0; intr_mccu = 4'h0; intr_rdc = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_quota_pulse();
    test_mccu_hold();
    test_mask_later();
    test_set_wins();
    test_cause();
    test_regs();
    test_back_to_back();
    test_reset_held();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
